count_sequencer: RTL and testbench
==================================

# count_sequencer

Run/pause controller for the board's count display. It owns a rate divider, sequences a two-digit BCD count from 01 to 99 with wrap, and takes its start/pause and rate-select inputs from the board pushbuttons. It sits between the raw KEY inputs and the seven-segment decode logic. It replaces a free-running divider with one that can be started, paused and re-rated while it runs.

## Interface
- `SLOW_DIV`, default 5_000_000: clk cycles per tick when KEY[1] is high (released).
- `FAST_DIV`, default 1_000_000: clk cycles per tick when KEY[1] is low (pressed).
- `DEBOUNCE_CYCLES`, default 50_000: stable-level cycles required by the debouncer.
- `clk` in 1: system clock, 50 MHz on board.
- `reset` in 1: synchronous, active-high; the only clock is `clk`.
- `KEY` in 2: active-low pushbuttons, asynchronous to `clk`. KEY[0] is start/pause; KEY[1] is rate select.
- `tick` out 1: one-cycle pulse each time the count advances.
- `wrap` out 1: one-cycle pulse coincident with `tick` when the count goes from 99 to 01.
- `ones` out 4: BCD ones digit.
- `tens` out 4: BCD tens digit.
- `running` out 1: high in state RUN.

## Operation
- Each KEY bit passes through its own 2-flop synchronizer, reset to 1.
- A press is a 1→0 transition of the conditioned KEY[0]. KEY[1] is used as a level.
- FSM states, reset to IDLE:
  - IDLE: digits are held at 01 and the divider at 0. A press moves to RUN.
  - RUN: the divider counts. A press moves to PAUSE.
  - PAUSE: divider and digits are frozen. A press moves back to RUN, and counting resumes from the frozen divider value.
- Divider:
  - 24-bit counter. The active divisor is SLOW_DIV when conditioned KEY[1]=1, otherwise FAST_DIV.
  - In RUN, when counter ≥ divisor−1: counter←0, tick←1, digits advance. Otherwise counter←counter+1.
  - The ≥ comparison means a switch from slow to fast with counter past FAST_DIV−1 produces a tick on the next edge. There is no overrun.
- Digits:
  - ones 9→0 with a tens carry.
  - At tens=9, ones=9 the next tick gives tens=0, ones=1 and wrap=1.
  - 00 is never displayed after reset.
- Simultaneous events:
  - A press in RUN on a tick edge: the tick and digit advance complete, and the state becomes PAUSE on the same edge.
  - A press in PAUSE/IDLE never generates a tick on that edge.
- Reset mid-operation returns everything to reset values on the next edge, regardless of state.
- Outputs at reset: tick=0, wrap=0, ones=1, tens=0, running=0.

## Timing
- All outputs are registered. tick, wrap and the new digit values appear together one cycle after the terminal-count cycle.
- In RUN from counter=0, tick repeats every divisor cycles exactly.
- Key latency without debounce: the state changes on the 3rd rising edge after KEY[0] falls (2 sync edges plus 1 edge-detect/FSM edge). `running` rises on that same edge.
- Key latency with debounce: the latency above plus DEBOUNCE_CYCLES.
- A KEY[1] change takes effect 2 edges after the pin changes, plus DEBOUNCE_CYCLES when debounce is enabled.

## Configuration
- `COUNT_SEQ_DEBOUNCE_EN` defined:
  - Each synchronized KEY bit feeds a debouncer.
  - The conditioned value updates only after the raw synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - Debounce counters reset to 0; conditioned values reset to 1.
- `COUNT_SEQ_DEBOUNCE_EN` undefined:
  - The conditioned value is the synchronizer output.
  - No debounce counters are instantiated.
  - Simulation uses this mode by default.

## Test plan
- Reset/start (SLOW_DIV=5, FAST_DIV=2, no debounce): reset, then a KEY[0] low pulse of 4 cycles. Required: running=1 on the 3rd edge, first tick 5 cycles later with ones=2, then ticks every 5 cycles.
- Rate switch: in RUN with counter=3, drive KEY[1] low. Required: a tick within 3 edges, then ticks every 2 cycles. Releasing KEY[1] restores the 5-cycle spacing.
- Wrap: run until tens=9, ones=9. Required: the next tick gives tens=0, ones=1, with wrap=1 for exactly one cycle coincident with tick.
- Pause/resume: pause with counter=2 and digits 37. Hold 20 cycles and require no tick and digits 37. Resume and require the next tick exactly 3 cycles after running rises, with digits 38.
- Simultaneous press and tick: time the press so the FSM edge equals a terminal-count edge. Required: the digits advance once, the state becomes PAUSE, and there are no further ticks.
- Reset mid-run, plus debounce (DEBOUNCE_CYCLES=4, macro defined):
  - Assert reset in RUN at digits 52. Required: ones=1, tens=0, running=0 on the next edge.
  - A 3-cycle KEY[0] glitch produces no state change. A 6-cycle press starts RUN.

Source files
------------

// File: rtl/count_sequencer.sv
// Start/pause/re-rate controller driving a 01..99 BCD count from pushbutton inputs.
// Optional per-key debouncing is enabled by defining COUNT_SEQ_DEBOUNCE_EN.
module count_sequencer #(
  parameter int unsigned SLOW_DIV        = 5_000_000,
  parameter int unsigned FAST_DIV        = 1_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] KEY,
  output logic       tick,
  output logic       wrap,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       running
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam logic [23:0] SLOW_LAST = 24'(SLOW_DIV - 1);
  localparam logic [23:0] FAST_LAST = 24'(FAST_DIV - 1);

  if (SLOW_DIV < 1 || SLOW_DIV > (1 << 24) || FAST_DIV < 1 || FAST_DIV > (1 << 24)
      || DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("count_sequencer: divisors must be 1..2^24 and DEBOUNCE_CYCLES >= 1");
  end

  logic [1:0] key_meta_q;
  logic [1:0] key_sync_q;
  logic [1:0] key_cond;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_meta_q <= 2'b11;
      key_sync_q <= 2'b11;
    end else begin
      key_meta_q <= KEY;
      key_sync_q <= key_meta_q;
    end
  end

`ifdef COUNT_SEQ_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0][DB_W-1:0] db_cnt_q;
  logic [1:0][DB_W-1:0] db_cnt_d;
  logic [1:0]           key_cond_q;
  logic [1:0]           key_cond_d;

  // Counter tracks consecutive cycles of disagreement; any agreement clears it.
  always_comb begin
    key_cond_d = key_cond_q;
    db_cnt_d   = '0;
    for (int i = 0; i < 2; i++) begin
      if (key_sync_q[i] != key_cond_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          key_cond_d[i] = key_sync_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt_q   <= '0;
      key_cond_q <= 2'b11;
    end else begin
      db_cnt_q   <= db_cnt_d;
      key_cond_q <= key_cond_d;
    end
  end

  assign key_cond = key_cond_q;
`else
  assign key_cond = key_sync_q;
`endif

  logic   key0_prev_q;
  logic   press;
  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      key0_prev_q <= 1'b1;
    end else begin
      key0_prev_q <= key_cond[0];
    end
  end

  assign press = key0_prev_q & ~key_cond[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (press) state_d = S_RUN;
      S_RUN:   if (press) state_d = S_PAUSE;
      S_PAUSE: if (press) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  logic [23:0] div_q;
  logic [23:0] div_d;
  logic [23:0] div_last;
  logic        terminal;
  logic [3:0]  ones_q;
  logic [3:0]  ones_d;
  logic [3:0]  tens_q;
  logic [3:0]  tens_d;
  logic        tick_q;
  logic        tick_d;
  logic        wrap_q;
  logic        wrap_d;
  logic        running_q;
  logic        running_d;

  // >= rather than == so a slow-to-fast switch past the fast limit ticks immediately.
  assign div_last = key_cond[1] ? SLOW_LAST : FAST_LAST;
  assign terminal = (state_q == S_RUN) && (div_q >= div_last);

  always_comb begin
    div_d     = div_q;
    ones_d    = ones_q;
    tens_d    = tens_q;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;
    running_d = (state_d == S_RUN);
    case (state_q)
      S_IDLE: begin
        div_d  = '0;
        ones_d = 4'd1;
        tens_d = 4'd0;
      end
      S_RUN: begin
        if (terminal) begin
          div_d  = '0;
          tick_d = 1'b1;
          if (ones_q == 4'd9) begin
            if (tens_q == 4'd9) begin
              ones_d = 4'd1;
              tens_d = 4'd0;
              wrap_d = 1'b1;
            end else begin
              ones_d = 4'd0;
              tens_d = tens_q + 4'd1;
            end
          end else begin
            ones_d = ones_q + 4'd1;
          end
        end else begin
          div_d = div_q + 24'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      ones_q    <= 4'd1;
      tens_q    <= 4'd0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
      running_q <= running_d;
    end
  end

  assign tick    = tick_q;
  assign wrap    = wrap_q;
  assign ones    = ones_q;
  assign tens    = tens_q;
  assign running = running_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer: stimulus queues expected ticks, a monitor checks them.
module tb_count_sequencer;

  localparam int SLOW = 5;
  localparam int FAST = 2;
  localparam int DB   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] KEY;
  logic       tick;
  logic       wrap;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       running;

  always #5 clk = ~clk;

  count_sequencer #(
    .SLOW_DIV(SLOW),
    .FAST_DIV(FAST),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .KEY(KEY),
    .tick(tick),
    .wrap(wrap),
    .ones(ones),
    .tens(tens),
    .running(running)
  );

  typedef struct {
    int at;
    int ones;
    int tens;
    bit wrap;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_n   = 0;
  int   val;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Model of the displayed count: 1..99 then back to 1 with wrap.
  task automatic push_tick(input int at);
    exp_t e;
    bit   w;
    w      = (val == 99);
    val    = w ? 1 : val + 1;
    e.at   = at;
    e.ones = val % 10;
    e.tens = val / 10;
    e.wrap = w;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic step_to(input int target);
    while (edge_n < target) step(1);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (q.size() > 0 && q[0].at < edge_n) begin
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL missed_tick: no tick at edge %0d (expected digits %0d%0d)", e.at, e.tens, e.ones);
    end
    if (tick) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tick: tick at edge %0d digits %0d%0d, none expected", edge_n, tens, ones);
      end else begin
        e = q.pop_front();
        check("tick_edge", edge_n, e.at);
        check("tick_ones", int'(ones), e.ones);
        check("tick_tens", int'(tens), e.tens);
        check("tick_wrap", int'(wrap), int'(e.wrap));
      end
    end else if (wrap) begin
      checks++;
      failures++;
      $display("FAIL wrap_without_tick: wrap=1 tick=0 at edge %0d", edge_n);
    end
  end

  initial begin
    int p0, t, u, v, w, x, p;
    reset = 1'b1;
    KEY   = 2'b11;
    val   = 1;
    step(3);
    reset = 1'b0;
    check("reset_ones", int'(ones), 1);
    check("reset_tens", int'(tens), 0);
    check("reset_running", int'(running), 0);
    check("reset_tick", int'(tick), 0);
    check("reset_wrap", int'(wrap), 0);
    step(2);
    check("idle_running", int'(running), 0);

    // Start: press latency 3 edges, first tick 5 edges after RUN.
    p0 = edge_n;
    KEY[0] = 1'b0;
    push_tick(p0 + 8);
    push_tick(p0 + 13);
    push_tick(p0 + 18);
    step(2);
    check("start_pre_running", int'(running), 0);
    step(1);
    check("start_running", int'(running), 1);
    step(1);
    KEY[0] = 1'b1;
    step_to(p0 + 18);

    // Rate switch with divider at 1: fast compare catches it at 3.
    t = edge_n;
    step(1);
    KEY[1] = 1'b0;
    push_tick(t + 4);
    push_tick(t + 6);
    push_tick(t + 8);
    push_tick(t + 10);
    step_to(t + 10);
    KEY[1] = 1'b1;
    push_tick(t + 12);
    push_tick(t + 17);
    push_tick(t + 22);
    step_to(t + 22);

    // Fast run up to 37, then pause with divider at 2.
    u = edge_n;
    KEY[1] = 1'b0;
    for (int k = 12; k <= 36; k++) push_tick(u + 3 + 2 * (k - 12));
    step_to(u + 51);
    KEY[1] = 1'b1;
    push_tick(u + 53);
    step_to(u + 52);
    KEY[0] = 1'b0;
    step_to(u + 54);
    check("pause_pre_running", int'(running), 1);
    step(1);
    check("pause_running", int'(running), 0);
    step(1);
    KEY[0] = 1'b1;
    step(20);
    check("pause_hold_ones", int'(ones), 7);
    check("pause_hold_tens", int'(tens), 3);
    check("pause_hold_running", int'(running), 0);

    // Resume: tick 3 edges after running rises.
    v = edge_n;
    KEY[0] = 1'b0;
    push_tick(v + 6);
    step(2);
    check("resume_pre_running", int'(running), 0);
    step(1);
    check("resume_running", int'(running), 1);
    step(1);
    KEY[0] = 1'b1;
    step_to(v + 6);

    // Fast run through 99 -> 01 wrap to 02.
    KEY[1] = 1'b0;
    for (int k = 0; k <= 62; k++) push_tick(v + 9 + 2 * k);
    step_to(v + 133);
    w = edge_n;
    KEY[1] = 1'b1;
    push_tick(w + 2);
    push_tick(w + 7);
    push_tick(w + 12);

    // Press lands on the terminal-count edge.
    step_to(w + 9);
    KEY[0] = 1'b0;
    step_to(w + 12);
    check("simul_running", int'(running), 0);
    step(1);
    KEY[0] = 1'b1;
    KEY[1] = 1'b0;
    step_to(w + 27);
    check("simul_hold_running", int'(running), 0);
    check("simul_hold_ones", int'(ones), 5);
    check("simul_hold_tens", int'(tens), 0);

    // Resume in fast mode to 52, then reset mid-run.
    x = edge_n;
    KEY[0] = 1'b0;
    for (int k = 6; k <= 52; k++) push_tick(x + 5 + 2 * (k - 6));
    step(3);
    check("resume2_running", int'(running), 1);
    step(1);
    KEY[0] = 1'b1;
    step_to(x + 97);
    reset = 1'b1;
    step(1);
    val = 1;
    check("midreset_ones", int'(ones), 1);
    check("midreset_tens", int'(tens), 0);
    check("midreset_running", int'(running), 0);
    check("midreset_tick", int'(tick), 0);
    reset = 1'b0;
    KEY   = 2'b11;
    step(3);

`ifdef COUNT_SEQ_DEBOUNCE_EN
    KEY[0] = 1'b0;
    step(3);
    KEY[0] = 1'b1;
    step(10);
    check("glitch_running", int'(running), 0);
    p = edge_n;
    KEY[0] = 1'b0;
    step(6);
    check("db_pre_running", int'(running), 0);
    step(1);
    check("db_running", int'(running), 1);
    KEY[0] = 1'b1;
`else
    p = edge_n;
    KEY[0] = 1'b0;
    step(1);
    KEY[0] = 1'b1;
    step(1);
    check("short_pre_running", int'(running), 0);
    step(1);
    check("short_running", int'(running), 1);
    check("short_edge", edge_n, p + 3);
`endif
    reset = 1'b1;
    step(1);
    check("final_reset_running", int'(running), 0);
    reset = 1'b0;
    step(5);
    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
